// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch control unit: state encoding and
// prescaler sizing helpers.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_LAP  = 2'b10,
        ST_STOP = 2'b11
    } sw_state_e;

    function automatic int calc_div(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

    function automatic int presc_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One pushbutton path: 2-flop synchronizer, stability counter and a
// registered single-cycle press pulse on an accepted 1->0 level change.
module key_debounce
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_key_n,
    output logic o_press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_level_d;
    logic          r_press;
    logic [CW-1:0] r_cnt;

    // Synchronize, debounce and detect the accepted press edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_level   <= 1'b1;
            r_level_d <= 1'b1;
            r_press   <= 1'b0;
            r_cnt     <= CNT_ZERO;
        end else begin
            r_sync1   <= i_key_n;
            r_sync2   <= r_sync1;
            r_level_d <= r_level;
            r_press   <= r_level_d & ~r_level;
            if (r_sync2 == r_level) begin
                r_cnt <= CNT_ZERO;
            end else if (r_cnt == CNT_LAST) begin
                // Counter would reach DEBOUNCE_CYCLES on this edge: accept.
                r_level <= r_sync2;
                r_cnt   <= CNT_ZERO;
            end else begin
                r_cnt <= r_cnt + CNT_ONE;
            end
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: debounced keys drive the IDLE/RUN/LAP/STOP FSM, and a
// prescaler produces the 100 Hz count enable for the BCD digit chain.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ          = 50000000,
    parameter int TICK_HZ         = 100,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       KEY_START_N,
    input  logic       KEY_LAP_N,
    input  logic       KEY_CLR_N,
    output logic       tick,
    output logic       clear,
    output logic       hold,
    output logic       running,
    output logic [1:0] state
);

    localparam int DIV = calc_div(CLK_HZ, TICK_HZ);
    localparam int PW  = presc_width(DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
    localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
    localparam logic [PW-1:0] PRESC_ZERO = PW'(0);

    logic          w_start;
    logic          w_lap;
    logic          w_clr;
    logic          w_counting;
    sw_state_e     r_state;
    logic [PW-1:0] r_presc;
    logic          r_tick;
    logic          r_clear;
    logic          r_hold;
    logic          r_running;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_start (
        .i_clk(CLOCK_50), .i_rst(reset), .i_key_n(KEY_START_N), .o_press(w_start)
    );
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_lap (
        .i_clk(CLOCK_50), .i_rst(reset), .i_key_n(KEY_LAP_N), .o_press(w_lap)
    );
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_clr (
        .i_clk(CLOCK_50), .i_rst(reset), .i_key_n(KEY_CLR_N), .o_press(w_clr)
    );

    assign w_counting = (r_state == ST_RUN) || (r_state == ST_LAP);

    // Control FSM with registered hold/running/clear; clr > start > lap.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_clear   <= 1'b0;
            r_hold    <= 1'b0;
            r_running <= 1'b0;
        end else begin
            r_clear <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state   <= ST_RUN;
                        r_running <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (w_start) begin
                        r_state   <= ST_STOP;
                        r_running <= 1'b0;
                    end else if (w_lap) begin
                        r_state <= ST_LAP;
                        r_hold  <= 1'b1;
                    end
                end
                ST_LAP: begin
                    if (w_start) begin
                        r_state   <= ST_STOP;
                        r_hold    <= 1'b0;
                        r_running <= 1'b0;
                    end else if (w_lap) begin
                        r_state <= ST_RUN;
                        r_hold  <= 1'b0;
                    end
                end
                ST_STOP: begin
                    if (w_clr) begin
                        r_state <= ST_IDLE;
                        r_clear <= 1'b1;
                    end else if (w_start) begin
                        r_state   <= ST_RUN;
                        r_running <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_hold    <= 1'b0;
                    r_running <= 1'b0;
                end
            endcase
        end
    end

    // Prescaler: counts in RUN/LAP, freezes in STOP, zeroed in/into IDLE.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_presc <= PRESC_ZERO;
            r_tick  <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            if (w_counting) begin
                if (r_presc == PRESC_LAST) begin
                    r_presc <= PRESC_ZERO;
                    // A start press here means we are leaving RUN/LAP.
                    r_tick  <= ~w_start;
                end else begin
                    r_presc <= r_presc + PRESC_ONE;
                end
            end else if ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_clr)) begin
                r_presc <= PRESC_ZERO;
            end
        end
    end

    assign tick    = r_tick;
    assign clear   = r_clear;
    assign hold    = r_hold;
    assign running = r_running;
    assign state   = r_state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed self-checking bench for stopwatch_ctrl with DIV=10 and a 4-cycle
// debounce: a key-press vector table plus hand-timed corner sequences.
module tb_stopwatch_ctrl;

    localparam int CLK_HZ  = 1000;
    localparam int TICK_HZ = 100;
    localparam int DEB     = 4;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_LAP  = 2'b10;
    localparam logic [1:0] S_STOP = 2'b11;

    logic       CLOCK_50 = 1'b0;
    logic       reset;
    logic       KEY_START_N;
    logic       KEY_LAP_N;
    logic       KEY_CLR_N;
    logic       tick;
    logic       clear;
    logic       hold;
    logic       running;
    logic [1:0] state;

    int n_chk  = 0;
    int n_fail = 0;
    int tick_cnt  = 0;
    int clear_cnt = 0;
    logic [1:0] model_st;

    typedef struct {
        logic [2:0] keys;   // {clr, lap, start}
        logic [1:0] st;
        logic       hd;
        logic       rn;
        int         clrs;
    } vec_t;

    vec_t tbl [16];

    stopwatch_ctrl #(
        .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .CLOCK_50(CLOCK_50), .reset(reset),
        .KEY_START_N(KEY_START_N), .KEY_LAP_N(KEY_LAP_N), .KEY_CLR_N(KEY_CLR_N),
        .tick(tick), .clear(clear), .hold(hold), .running(running), .state(state)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) begin
        if (tick === 1'b1) tick_cnt <= tick_cnt + 1;
        if (clear === 1'b1) clear_cnt <= clear_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic press_key(input logic [2:0] keys, input logic [1:0] exp_st,
                             input logic exp_hd, input logic exp_rn,
                             input int exp_clr, input string tag);
        int c0;
        int t0;
        c0 = clear_cnt;
        {KEY_CLR_N, KEY_LAP_N, KEY_START_N} = ~keys;
        repeat (7) @(negedge CLOCK_50);
        check({tag, "_early"}, state, model_st);
        @(negedge CLOCK_50);
        check({tag, "_state"}, state, exp_st);
        check({tag, "_hold"}, hold, exp_hd);
        check({tag, "_running"}, running, exp_rn);
        {KEY_CLR_N, KEY_LAP_N, KEY_START_N} = 3'b111;
        t0 = tick_cnt;
        repeat (12) @(negedge CLOCK_50);
        check({tag, "_clears"}, clear_cnt - c0, exp_clr);
        check({tag, "_ticking"}, (tick_cnt != t0), exp_rn);
        check({tag, "_stable"}, state, exp_st);
        model_st = exp_st;
    endtask

    initial begin
        int t0;
        int hits;

        tbl[0]  = '{3'b010, S_STOP, 1'b0, 1'b0, 0};
        tbl[1]  = '{3'b001, S_RUN,  1'b0, 1'b1, 0};
        tbl[2]  = '{3'b100, S_RUN,  1'b0, 1'b1, 0};
        tbl[3]  = '{3'b010, S_LAP,  1'b1, 1'b1, 0};
        tbl[4]  = '{3'b100, S_LAP,  1'b1, 1'b1, 0};
        tbl[5]  = '{3'b010, S_RUN,  1'b0, 1'b1, 0};
        tbl[6]  = '{3'b010, S_LAP,  1'b1, 1'b1, 0};
        tbl[7]  = '{3'b011, S_STOP, 1'b0, 1'b0, 0};
        tbl[8]  = '{3'b011, S_RUN,  1'b0, 1'b1, 0};
        tbl[9]  = '{3'b011, S_STOP, 1'b0, 1'b0, 0};
        tbl[10] = '{3'b110, S_IDLE, 1'b0, 1'b0, 1};
        tbl[11] = '{3'b010, S_IDLE, 1'b0, 1'b0, 0};
        tbl[12] = '{3'b100, S_IDLE, 1'b0, 1'b0, 0};
        tbl[13] = '{3'b101, S_RUN,  1'b0, 1'b1, 0};
        tbl[14] = '{3'b001, S_STOP, 1'b0, 1'b0, 0};
        tbl[15] = '{3'b100, S_IDLE, 1'b0, 1'b0, 1};

        // Reset state
        reset = 1'b1;
        {KEY_CLR_N, KEY_LAP_N, KEY_START_N} = 3'b111;
        repeat (3) @(negedge CLOCK_50);
        check("rst_state", state, S_IDLE);
        check("rst_tick", tick, 1'b0);
        check("rst_clear", clear, 1'b0);
        check("rst_hold", hold, 1'b0);
        check("rst_running", running, 1'b0);
        reset = 1'b0;
        model_st = S_IDLE;
        repeat (3) @(negedge CLOCK_50);

        // Start latency and tick cadence
        KEY_START_N = 1'b0;
        repeat (7) @(negedge CLOCK_50);
        check("start_early", state, S_IDLE);
        @(negedge CLOCK_50);
        check("start_run", state, S_RUN);
        check("start_running", running, 1'b1);
        KEY_START_N = 1'b1;
        hits = 0;
        for (int i = 0; i < 9; i++) begin
            @(negedge CLOCK_50);
            if (tick === 1'b1) hits++;
        end
        check("first_tick_early", hits, 0);
        @(negedge CLOCK_50);
        check("first_tick", tick, 1'b1);
        t0 = tick_cnt;
        repeat (1000) @(negedge CLOCK_50);
        check("tick_count_1000", tick_cnt - t0, 100);
        check("tick_no_drift", tick, 1'b1);
        model_st = S_RUN;

        // Bouncing start key gives exactly one transition
        for (int i = 0; i < 12; i++) begin
            KEY_START_N = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
            @(negedge CLOCK_50);
        end
        check("bounce_no_change", state, S_RUN);
        KEY_START_N = 1'b0;
        repeat (7) @(negedge CLOCK_50);
        check("bounce_early", state, S_RUN);
        @(negedge CLOCK_50);
        check("bounce_stop", state, S_STOP);
        repeat (20) @(negedge CLOCK_50);
        check("bounce_single", state, S_STOP);
        KEY_START_N = 1'b1;
        repeat (12) @(negedge CLOCK_50);
        model_st = S_STOP;

        for (int i = 0; i < 16; i++)
            press_key(tbl[i].keys, tbl[i].st, tbl[i].hd, tbl[i].rn, tbl[i].clrs,
                      $sformatf("vec%0d", i));

        // Stop with prescaler at 6, then resume
        KEY_START_N = 1'b0;
        repeat (8) @(negedge CLOCK_50);
        check("p6_run", state, S_RUN);
        KEY_START_N = 1'b1;
        repeat (8) @(negedge CLOCK_50);
        KEY_START_N = 1'b0;
        repeat (7) @(negedge CLOCK_50);
        check("p6_stop_early", state, S_RUN);
        @(negedge CLOCK_50);
        check("p6_stop", state, S_STOP);
        KEY_START_N = 1'b1;
        t0 = tick_cnt;
        repeat (50) @(negedge CLOCK_50);
        check("stop_no_tick", tick_cnt - t0, 0);
        KEY_START_N = 1'b0;
        repeat (8) @(negedge CLOCK_50);
        check("resume_run", state, S_RUN);
        KEY_START_N = 1'b1;
        hits = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLOCK_50);
            if (tick === 1'b1) hits++;
        end
        check("resume_tick_early", hits, 0);
        @(negedge CLOCK_50);
        check("resume_tick", tick, 1'b1);
        model_st = S_RUN;

        // Clear pulse width
        press_key(3'b001, S_STOP, 1'b0, 1'b0, 0, "to_stop");
        KEY_CLR_N = 1'b0;
        repeat (7) @(negedge CLOCK_50);
        check("clr_early", state, S_STOP);
        @(negedge CLOCK_50);
        check("clr_idle", state, S_IDLE);
        check("clr_pulse", clear, 1'b1);
        @(negedge CLOCK_50);
        check("clr_pulse_end", clear, 1'b0);
        KEY_CLR_N = 1'b1;
        repeat (12) @(negedge CLOCK_50);
        model_st = S_IDLE;

        // Coincident start and clr in STOP: clr wins
        press_key(3'b001, S_RUN, 1'b0, 1'b1, 0, "co_run");
        press_key(3'b001, S_STOP, 1'b0, 1'b0, 0, "co_stop");
        {KEY_CLR_N, KEY_START_N} = 2'b00;
        repeat (8) @(negedge CLOCK_50);
        check("co_idle", state, S_IDLE);
        check("co_clear", clear, 1'b1);
        @(negedge CLOCK_50);
        check("co_clear_end", clear, 1'b0);
        {KEY_CLR_N, KEY_START_N} = 2'b11;
        repeat (12) @(negedge CLOCK_50);
        check("co_stays_idle", state, S_IDLE);

        // Async reset mid-RUN with start held through reset release
        KEY_START_N = 1'b0;
        repeat (8) @(negedge CLOCK_50);
        check("ar_run", state, S_RUN);
        repeat (5) @(negedge CLOCK_50);
        #2 reset = 1'b1;
        #1;
        check("ar_state", state, S_IDLE);
        check("ar_running", running, 1'b0);
        check("ar_hold", hold, 1'b0);
        check("ar_tick", tick, 1'b0);
        check("ar_clear", clear, 1'b0);
        @(negedge CLOCK_50);
        reset = 1'b0;
        repeat (7) @(negedge CLOCK_50);
        check("ar_held_early", state, S_IDLE);
        @(negedge CLOCK_50);
        check("ar_held_press", state, S_RUN);
        KEY_START_N = 1'b1;
        repeat (5) @(negedge CLOCK_50);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
